fifo_word_packer: RTL and testbench

Read-side consumer placed directly downstream of `fifo_sync`. Pops DATA_WIDTH-bit entries from the FIFO and packs PACK_COUNT consecutive entries into one OUT_WIDTH-bit word, presented on a valid/ready output port. A flush input emits a partial word early. Drives the FIFO's `r_en` from `empty`, so the FIFO never underflows and the packer never overruns.

---
 rtl/fifo_word_packer_pkg.sv | 13 +
 rtl/fifo_word_packer.sv | 102 ++++++++++
 tb/tb_fifo_word_packer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared constants and state encoding for the FIFO word packer.
package fifo_word_packer_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_PACK_COUNT = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops entries from a synchronous FIFO and packs PACK_COUNT of them into one
// wide word on a valid/ready port; flush emits a partial word early.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int PACK_COUNT = DEF_PACK_COUNT,
  localparam int OUT_WIDTH  = DATA_WIDTH * PACK_COUNT,
  localparam int CNT_W      = $clog2(PACK_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]      out_count
);

  localparam logic [CNT_W:0]   FULL_SUM = (CNT_W + 1)'(PACK_COUNT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(PACK_COUNT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] fill;
  logic             pending;
  logic             flush_req;
  logic [CNT_W:0]   occupancy;
  logic             word_done;
  logic             handshake;
  logic             flush_hit;

  // Lanes already written plus the read still in flight; never exceeds PACK_COUNT.
  assign occupancy = {1'b0, fill} + {{CNT_W{1'b0}}, pending};
  assign word_done = pending && (fill == LAST);
  assign handshake = (state == HOLD) && out_ready;
  // A flush only matters once something is captured or on its way.
  assign flush_hit = (flush || flush_req) && (occupancy != '0);

  assign fifo_r_en = rst && !fifo_empty && (state == FILL) && !flush_req &&
                     (occupancy < FULL_SUM);
  assign out_valid = (state == HOLD);
  assign out_count = (state == HOLD) ? fill : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  // Next state: a flush with a read in flight detours through DRAIN so the
  // last entry lands before the word is presented.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (word_done)      state_nxt = HOLD;
        else if (flush_hit) state_nxt = (pending || fifo_r_en) ? DRAIN : HOLD;
      end
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Fill counter, in-flight read flag and latched flush request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill      <= '0;
      pending   <= 1'b0;
      flush_req <= 1'b0;
    end else begin
      pending <= fifo_r_en;
      if (handshake) begin
        fill      <= '0;
        flush_req <= 1'b0;
      end else begin
        if (pending) fill <= fill + CNT_W'(1);
        if ((state == FILL) && flush && (occupancy != '0) && !word_done)
          flush_req <= 1'b1;
      end
    end
  end

  // Lane bank: each lane captures when it is the next slot to fill and is
  // cleared after the word is taken, so unused lanes always read as zero.
  for (genvar i = 0; i < PACK_COUNT; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane;

    // Per-lane capture/clear register.
    always_ff @(posedge clk) begin
      if (!rst || handshake)                    lane <= '0;
      else if (pending && (fill == CNT_W'(i)))  lane <= fifo_rdata;
    end

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = lane;
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a small depth-4 FIFO model.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic [3:0]  fifo_rdata = 4'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_count;

  always #5 clk = ~clk;

  fifo_word_packer dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count)
  );

  // Depth-4 synchronous FIFO model sharing rst; force_ne fakes a non-empty
  // FIFO while reset holds the real one clear.
  logic [3:0] mem [4];
  logic [1:0] wp = 2'd0;
  logic [1:0] rp = 2'd0;
  int         cnt = 0;
  logic       w_en = 1'b0;
  logic [3:0] wdata = 4'h0;
  logic       force_ne = 1'b0;

  assign fifo_empty = (cnt == 0) && !force_ne;

  always @(posedge clk) begin
    if (!rst) begin
      wp <= 2'd0;
      rp <= 2'd0;
      cnt <= 0;
      fifo_rdata <= 4'h0;
    end else begin
      if (w_en && cnt < 4) begin
        mem[wp] <= wdata;
        wp <= wp + 2'd1;
      end
      if (fifo_r_en && cnt != 0) begin
        fifo_rdata <= mem[rp];
        rp <= rp + 2'd1;
      end
      cnt <= cnt + ((w_en && cnt < 4) ? 1 : 0) - ((fifo_r_en && cnt != 0) ? 1 : 0);
    end
  end

  // Event log sampled on the falling edge.
  int          cyc = 0;
  int          ren_log[$];
  int          flush_cyc[$];
  int          word_cyc[$];
  logic [15:0] word_data[$];
  logic [2:0]  word_cnt[$];
  int          ren_in_hold = 0;
  int          unstable = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_data = 16'h0;
  logic [2:0]  prev_count = 3'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_en) ren_log.push_back(cyc);
    if (flush) flush_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      word_cyc.push_back(cyc);
      word_data.push_back(out_data);
      word_cnt.push_back(out_count);
    end
    if (out_valid && fifo_r_en) ren_in_hold <= ren_in_hold + 1;
    if (prev_wait && (!out_valid || out_data != prev_data || out_count != prev_count))
      unstable <= unstable + 1;
    prev_wait  <= out_valid && !out_ready;
    prev_data  <= out_data;
    prev_count <= out_count;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_range(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      w_en  = 1'b1;
      wdata = 4'(first + k);
      tick(1);
    end
    w_en = 1'b0;
  endtask

  task automatic clear_log();
    ren_log.delete();
    flush_cyc.delete();
    word_cyc.delete();
    word_data.delete();
    word_cnt.delete();
  endtask

  initial begin
    // Reset with the FIFO reporting data available.
    rst = 1'b0;
    force_ne = 1'b1;
    tick(2);
    check_eq("rst_r_en", fifo_r_en, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 16'h0000);
    check_eq("rst_count", out_count, 0);
    force_ne = 1'b0;
    rst = 1'b1;
    tick(1);

    // Full word, sink always ready.
    out_ready = 1'b1;
    clear_log();
    wr_range(1, 4);
    tick(10);
    check_eq("full_ren_cnt", ren_log.size(), 4);
    check_eq("full_ren_run", ren_log.size() == 4 ? ren_log[3] - ren_log[0] : -1, 3);
    check_eq("full_words", word_data.size(), 1);
    check_eq("full_data", word_data.size() > 0 ? {16'h0, word_data[0]} : 32'hDEAD, 16'h4321);
    check_eq("full_count", word_cnt.size() > 0 ? {29'h0, word_cnt[0]} : 32'hDEAD, 4);
    check_eq("full_latency",
             (word_cyc.size() > 0 && ren_log.size() > 0) ? word_cyc[0] - ren_log[0] : -1, 5);

    // Backpressure: first word held while FIFO fills up.
    clear_log();
    out_ready = 1'b0;
    wr_range(1, 8);
    tick(6);
    check_eq("bp_valid", out_valid, 1);
    check_eq("bp_data", out_data, 16'h4321);
    check_eq("bp_count", out_count, 4);
    check_eq("bp_fifo_full", cnt, 4);
    check_eq("bp_ren_cnt", ren_log.size(), 4);
    check_eq("bp_ren_in_hold", ren_in_hold, 0);
    check_eq("bp_stable", unstable, 0);
    out_ready = 1'b1;
    tick(20);
    check_eq("bp_words", word_data.size(), 2);
    check_eq("bp_word0", word_data.size() > 0 ? {16'h0, word_data[0]} : 32'hDEAD, 16'h4321);
    check_eq("bp_word1", word_data.size() > 1 ? {16'h0, word_data[1]} : 32'hDEAD, 16'h8765);

    // Flush with the second read still in flight.
    clear_log();
    wr_range(5, 2);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(8);
    check_eq("fl_ren_cnt", ren_log.size(), 2);
    check_eq("fl_words", word_data.size(), 1);
    check_eq("fl_data", word_data.size() > 0 ? {16'h0, word_data[0]} : 32'hDEAD, 16'h0065);
    check_eq("fl_count", word_cnt.size() > 0 ? {29'h0, word_cnt[0]} : 32'hDEAD, 2);
    check_eq("fl_latency",
             (word_cyc.size() > 0 && flush_cyc.size() > 0) ? word_cyc[0] - flush_cyc[0] : -1, 2);

    // Flush with nothing captured is ignored.
    clear_log();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(20);
    check_eq("ign_words", word_data.size(), 0);
    check_eq("ign_ren", ren_log.size(), 0);
    wr_range(1, 4);
    tick(10);
    check_eq("ign_after_words", word_data.size(), 1);
    check_eq("ign_after_data", word_data.size() > 0 ? {16'h0, word_data[0]} : 32'hDEAD, 16'h4321);
    check_eq("ign_after_count", word_cnt.size() > 0 ? {29'h0, word_cnt[0]} : 32'hDEAD, 4);

    // Reset after two captures with a third read in flight.
    clear_log();
    wr_range(1, 3);
    tick(1);
    rst = 1'b0;
    tick(1);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_data", out_data, 16'h0000);
    check_eq("mid_rst_count", out_count, 0);
    rst = 1'b1;
    clear_log();
    wr_range(9, 4);
    tick(10);
    check_eq("mid_words", word_data.size(), 1);
    check_eq("mid_data", word_data.size() > 0 ? {16'h0, word_data[0]} : 32'hDEAD, 16'hCBA9);
    check_eq("mid_count", word_cnt.size() > 0 ? {29'h0, word_cnt[0]} : 32'hDEAD, 4);
    check_eq("end_ren_in_hold", ren_in_hold, 0);
    check_eq("end_stable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
